// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half adders and an OR gate.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    assign h1_s = a ^ b;
    assign h1_c = a & b;
    assign s    = h1_s ^ cin;
    assign h2_c = h1_s & cin;
    assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready handshakes on both sides.
// Optional subtraction (op_sub port) is built when SERIAL_SUB_EN is defined.
module serial_adder_core
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               cin;
    logic [CNT_W-1:0]   counter;
    logic               fa_s;
    logic               fa_cout;

    serial_fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cin),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // NOTE: reset is sampled on the clock edge and every register uses <= so all
    // state advances together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            cin       <= 1'b0;
            counter   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= op_a;
`ifdef SERIAL_SUB_EN
                        b_sh     <= op_sub ? ~op_b : op_b;
                        cin      <= op_sub;
`else
                        b_sh     <= op_b;
                        cin      <= 1'b0;
`endif
                        counter  <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum     <= {fa_s, sum[WIDTH-1:1]};
                    cin     <= fa_cout;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        // cin here is the carry into the MSB position
                        carry_out <= fa_cout;
                        overflow  <= fa_cout ^ cin;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
